// File: rtl/mod_n_timer_ctrl.sv
// Command-driven modulo-N timer: runs a counter through reps full 0..N-1 periods, pulses wrap/done.
// Optional MOD_N_TIMER_AUTORELOAD_EN: DONE restarts the same command instead of returning to IDLE.
module mod_n_timer_ctrl #(
  parameter int WIDTH  = 4,
  parameter int REPS_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [WIDTH-1:0]  cmd_mod,
  input  logic [REPS_W-1:0] cmd_reps,
  input  logic              abort,
  input  logic              pause,
  output logic [WIDTH-1:0]  count,
  output logic              wrap,
  output logic              done,
  output logic              busy,
  output logic [REPS_W-1:0] period_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   mod_m1, count_nx;
  logic [REPS_W-1:0]  reps, pcnt_nx, pcnt_inc;
  logic               wrap_nx, accept;

  assign cmd_ready = (state == IDLE) && !abort;
  assign accept    = cmd_valid && cmd_ready;
  assign done      = (state == DONE);
  assign busy      = (state != IDLE);
  assign pcnt_inc  = period_cnt + 1'b1;

  always_comb begin
    state_nx = state;
    count_nx = count;
    pcnt_nx  = period_cnt;
    wrap_nx  = 1'b0;
    case (state)
      IDLE: if (accept) begin
        state_nx = RUN;
        count_nx = '0;
        pcnt_nx  = '0;
      end
      RUN: begin
        if (abort) begin
          state_nx = IDLE;
          count_nx = '0;
          pcnt_nx  = '0;
        end else if (!pause) begin
          if (count != mod_m1) begin
            count_nx = count + 1'b1;
          end else begin
            count_nx = '0;
            wrap_nx  = 1'b1;
            pcnt_nx  = pcnt_inc;
            // reps==0 means free-running; period_cnt just rolls over
            if (reps != '0 && pcnt_inc == reps) state_nx = DONE;
          end
        end
      end
      DONE: begin
        if (abort) begin
          state_nx = IDLE;
          count_nx = '0;
          pcnt_nx  = '0;
        end else begin
`ifdef MOD_N_TIMER_AUTORELOAD_EN
          state_nx = RUN;
          count_nx = '0;
          pcnt_nx  = '0;
`else
          state_nx = IDLE;
`endif
        end
      end
      default: begin
        state_nx = IDLE;
        count_nx = '0;
        pcnt_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      wrap       <= 1'b0;
      period_cnt <= '0;
      mod_m1     <= '0;
      reps       <= '0;
    end else begin
      state      <= state_nx;
      count      <= count_nx;
      wrap       <= wrap_nx;
      period_cnt <= pcnt_nx;
      // cmd_mod==0 wraps to all-ones, i.e. a full 2^WIDTH period
      if (accept) begin
        mod_m1 <= cmd_mod - 1'b1;
        reps   <= cmd_reps;
      end
    end
  end

endmodule
